// File: rtl/pc_stack_seq.sv
`default_nettype none
// ============================================================================
// pc_stack_seq : program-counter sequencer with return stack and branch hold
// Revision     : 1.0
// ============================================================================
module pc_stack_seq #(
   parameter int                ADDR_W    = 12,
   parameter int                DEPTH     = 4,
   parameter int                COND_HOLD = 1,
   parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       en,
   input  logic [15:0]                IR,
   input  logic [3:0]                 CCR,
   output logic [ADDR_W-1:0]          pc_output,
   output logic                       hold,
   output logic [$clog2(DEPTH+1)-1:0] sp,
   output logic                       stk_ovf,
   output logic                       stk_unf
);

   localparam int SP_W  = $clog2(DEPTH + 1);
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic [SP_W-1:0]     sp_q, sp_d;
   logic                ovf_q, ovf_d;
   logic                unf_q, unf_d;

   // Sized to a power of two so the index width matches the array exactly.
   logic [ADDR_W-1:0]   stack_q [2**IDX_W];

   logic                push_en;
   logic [IDX_W-1:0]    push_idx;
   logic [IDX_W-1:0]    pop_idx;
   logic [ADDR_W-1:0]   pc_inc;
   logic [ADDR_W-1:0]   jmp_tgt;
   logic [ADDR_W-1:0]   rel_off;
   logic                cond_true;
   logic                stack_full;
   logic                unused_ccr;

   assign unused_ccr = CCR[1];
   assign pc_inc     = pc_q + ADDR_W'(1);
   assign jmp_tgt    = ADDR_W'(IR[11:0]);
   assign rel_off    = ADDR_W'($signed(IR[11:0]));
   assign stack_full = (sp_q == SP_W'(DEPTH));
   assign push_idx   = sp_q[IDX_W-1:0];
   assign pop_idx    = IDX_W'(sp_q - SP_W'(1));

   always_comb begin
      cond_true = 1'b0;
      case (IR[15:12])
         4'h9:    cond_true = CCR[2];
         4'hA:    cond_true = CCR[3];
         4'hB:    cond_true = CCR[0];
         default: cond_true = 1'b0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      sp_d    = sp_q;
      ovf_d   = ovf_q;
      unf_d   = unf_q;
      push_en = 1'b0;
      if (en) begin
         case (state_q)
            ST_IDLE: state_d = ST_RUN;
            ST_HOLD: begin
               // CCR is sampled here, in the second cycle of the branch.
               pc_d    = cond_true ? jmp_tgt : pc_inc;
               state_d = ST_RUN;
            end
            ST_RUN: begin
               case (IR[15:12])
                  4'h0: begin
                     if (IR[11:8] == 4'hD) begin
                        if (sp_q != '0) begin
                           pc_d = stack_q[pop_idx];
                           sp_d = sp_q - SP_W'(1);
                        end else begin
                           pc_d  = pc_inc;
                           unf_d = 1'b1;
                        end
                     end else begin
                        pc_d = pc_inc;
                     end
                  end
                  4'h8: pc_d = jmp_tgt;
                  4'h9, 4'hA, 4'hB: begin
                     if (COND_HOLD != 0) state_d = ST_HOLD;
                     else                pc_d    = cond_true ? jmp_tgt : pc_inc;
                  end
                  4'hE: begin
                     if (stack_full) begin
                        ovf_d = 1'b1;
                     end else begin
                        push_en = 1'b1;
                        sp_d    = sp_q + SP_W'(1);
                     end
                     pc_d = pc_q + rel_off;
                  end
                  default: pc_d = pc_inc;
               endcase
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         pc_q    <= RESET_VEC;
         sp_q    <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         sp_q    <= sp_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_en && !rst) stack_q[push_idx] <= pc_inc;
   end

   assign pc_output = pc_q;
   assign hold      = (state_q == ST_HOLD);
   assign sp        = sp_q;
   assign stk_ovf   = ovf_q;
   assign stk_unf   = unf_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_stack_seq.sv
`default_nettype none
// Bench for pc_stack_seq: directed scenarios then random instructions,
// compared each cycle against a queue-based reference of the sequencer.
module tb_pc_stack_seq;

   localparam int AW    = 12;
   localparam int DEPTH = 2;
   localparam int MASK  = (1 << AW) - 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          en  = 1'b0;
   logic [15:0]   IR  = '0;
   logic [3:0]    CCR = '0;
   logic [AW-1:0] pc_output;
   logic          hold;
   logic [1:0]    sp;
   logic          stk_ovf;
   logic          stk_unf;

   int tests = 0;
   int fails = 0;

   int m_pc    = 0;
   bit m_armed = 0;
   bit m_hold  = 0;
   bit m_ovf   = 0;
   bit m_unf   = 0;
   int m_stack [$];

   pc_stack_seq #(
      .ADDR_W    (AW),
      .DEPTH     (DEPTH),
      .COND_HOLD (1),
      .RESET_VEC (12'h000)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .IR        (IR),
      .CCR       (CCR),
      .pc_output (pc_output),
      .hold      (hold),
      .sp        (sp),
      .stk_ovf   (stk_ovf),
      .stk_unf   (stk_unf)
   );

   always #5 clk = ~clk;

   function automatic bit cond_of(input logic [15:0] ir, input logic [3:0] ccr);
      if (ir[15:12] == 4'h9) return ccr[2];
      if (ir[15:12] == 4'hA) return ccr[3];
      if (ir[15:12] == 4'hB) return ccr[0];
      return 1'b0;
   endfunction

   task automatic model(input bit r, input bit e, input logic [15:0] ir, input logic [3:0] ccr);
      int off;
      if (r) begin
         m_pc = 0; m_armed = 0; m_hold = 0; m_ovf = 0; m_unf = 0;
         m_stack.delete();
      end else if (e) begin
         if (!m_armed) begin
            m_armed = 1;
         end else if (m_hold) begin
            m_pc   = cond_of(ir, ccr) ? int'(ir[11:0]) : ((m_pc + 1) & MASK);
            m_hold = 0;
         end else if (ir[15:12] == 4'h0 && ir[11:8] == 4'hD) begin
            if (m_stack.size() > 0) m_pc = m_stack.pop_back();
            else begin m_pc = (m_pc + 1) & MASK; m_unf = 1; end
         end else if (ir[15:12] == 4'h8) begin
            m_pc = int'(ir[11:0]);
         end else if (ir[15:12] >= 4'h9 && ir[15:12] <= 4'hB) begin
            m_hold = 1;
         end else if (ir[15:12] == 4'hE) begin
            off = ir[11] ? int'(ir[11:0]) - 4096 : int'(ir[11:0]);
            if (m_stack.size() < DEPTH) m_stack.push_back((m_pc + 1) & MASK);
            else m_ovf = 1;
            m_pc = (m_pc + off) & MASK;
         end else begin
            m_pc = (m_pc + 1) & MASK;
         end
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input bit r, input bit e, input logic [15:0] ir, input logic [3:0] ccr);
      rst = r; en = e; IR = ir; CCR = ccr;
      @(posedge clk);
      model(r, e, ir, ccr);
      #1;
      check("pc",  32'(pc_output), 32'(m_pc));
      check("hold", 32'(hold),     32'(m_hold));
      check("sp",  32'(sp),        32'(m_stack.size()));
      check("ovf", 32'(stk_ovf),   32'(m_ovf));
      check("unf", 32'(stk_unf),   32'(m_unf));
   endtask

   initial begin
      logic [15:0] r_ir;
      logic [15:0] last_ir;
      bit          r_rst, r_en;
      int          k;

      // Reset and arm
      step(1, 0, 16'h0000, 4'h0);
      check("rst_pc", 32'(pc_output), 32'h000);
      step(0, 1, 16'h0000, 4'h0);
      check("arm_pc", 32'(pc_output), 32'h000);
      step(0, 1, 16'h0000, 4'h0);
      step(0, 1, 16'h0000, 4'h0);
      check("inc_pc", 32'(pc_output), 32'h002);

      // Absolute jump then increment
      step(0, 1, 16'h8005, 4'h0);
      step(0, 1, 16'h8123, 4'h0);
      check("jmp_pc", 32'(pc_output), 32'h123);
      step(0, 1, 16'h1000, 4'h0);
      check("after_jmp", 32'(pc_output), 32'h124);

      // Held conditional: taken, not taken, and stalled by en=0
      step(0, 1, 16'h8010, 4'h0);
      step(0, 1, 16'h9040, 4'b0100);
      check("jze_hold", 32'({hold, pc_output}), 32'h1010);
      step(0, 1, 16'h9040, 4'b0100);
      check("jze_taken", 32'({hold, pc_output}), 32'h0040);
      step(0, 1, 16'h8010, 4'h0);
      step(0, 1, 16'h9040, 4'b0000);
      step(0, 1, 16'h9040, 4'b0000);
      check("jze_not", 32'(pc_output), 32'h011);
      step(0, 1, 16'h8030, 4'h0);
      step(0, 1, 16'hB050, 4'b0001);
      step(0, 0, 16'hB050, 4'b0001);
      check("stall_hold", 32'({hold, pc_output}), 32'h1030);
      step(0, 1, 16'hB050, 4'b0001);
      check("jcy_taken", 32'(pc_output), 32'h050);

      // Relative call and return
      step(0, 1, 16'h8020, 4'h0);
      step(0, 1, 16'hEFFE, 4'h0);
      check("bsr_pc", 32'({2'b00, sp, pc_output}), 32'h101E);
      step(0, 1, 16'h0D00, 4'h0);
      check("ret_pc", 32'({2'b00, sp, pc_output}), 32'h0021);

      // Overflow and underflow
      step(0, 1, 16'hE010, 4'h0);
      step(0, 1, 16'hE010, 4'h0);
      step(0, 1, 16'hE010, 4'h0);
      check("ovf_state", 32'({stk_ovf, 1'b0, sp, pc_output}), 32'hA051);
      step(0, 1, 16'h0D00, 4'h0);
      check("ret1", 32'(pc_output), 32'h032);
      step(0, 1, 16'h0D00, 4'h0);
      check("ret2", 32'(pc_output), 32'h022);
      step(0, 1, 16'h0D00, 4'h0);
      check("unf_state", 32'({stk_unf, 1'b0, sp, pc_output}), 32'h8023);

      // Wrap, and reset during a held branch
      step(0, 1, 16'h8FFF, 4'h0);
      step(0, 1, 16'h0000, 4'h0);
      check("wrap_pc", 32'(pc_output), 32'h000);
      step(0, 1, 16'hA000, 4'h0);
      step(1, 1, 16'hA000, 4'h8);
      check("rst_hold", 32'({hold, pc_output}), 32'h0000);
      step(0, 1, 16'h0000, 4'h0);
      check("rearm_pc", 32'(pc_output), 32'h000);
      step(0, 1, 16'h0000, 4'h0);
      check("rearm_inc", 32'(pc_output), 32'h001);

      // Random instruction mix
      last_ir = 16'h0000;
      for (int i = 0; i < 400; i++) begin
         k = $urandom_range(0, 9);
         case (k)
            0, 1:    r_ir = {8'h0D, 8'($urandom)};
            2:       r_ir = {4'h8, 12'($urandom)};
            3, 4:    r_ir = {4'(9 + $urandom_range(0, 2)), 12'($urandom)};
            5, 6:    r_ir = {4'hE, 12'($urandom)};
            default: r_ir = 16'($urandom);
         endcase
         if (m_hold) r_ir = last_ir;
         r_rst = ($urandom_range(0, 63) == 0);
         r_en  = ($urandom_range(0, 7) != 0);
         step(r_rst, r_en, r_ir, 4'($urandom));
         last_ir = r_ir;
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
